// File: rtl/wb_rr_arbiter.sv
// Two-master Wishbone round-robin arbiter in front of one shared slave port.
// A stalled strobe is force-acked with 32'hDEAD_BEEF after TIMEOUT cycles (legal range 1..255).
module wb_rr_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,

  input  logic        m0_wbs_cyc_i,
  input  logic        m0_wbs_stb_i,
  input  logic        m0_wbs_we_i,
  input  logic [3:0]  m0_wbs_sel_i,
  input  logic [31:0] m0_wbs_adr_i,
  input  logic [31:0] m0_wbs_dat_i,
  output logic        m0_wbs_ack_o,
  output logic [31:0] m0_wbs_dat_o,

  input  logic        m1_wbs_cyc_i,
  input  logic        m1_wbs_stb_i,
  input  logic        m1_wbs_we_i,
  input  logic [3:0]  m1_wbs_sel_i,
  input  logic [31:0] m1_wbs_adr_i,
  input  logic [31:0] m1_wbs_dat_i,
  output logic        m1_wbs_ack_o,
  output logic [31:0] m1_wbs_dat_o,

  output logic        s_wbs_cyc_i,
  output logic        s_wbs_stb_i,
  output logic        s_wbs_we_i,
  output logic [3:0]  s_wbs_sel_i,
  output logic [31:0] s_wbs_adr_i,
  output logic [31:0] s_wbs_dat_i,
  input  logic        s_wbs_ack_o,
  input  logic [31:0] s_wbs_dat_o,

  output logic [1:0]  gnt_o,
  output logic        tmo_o,
  input  logic        tmo_clr_i
);

  localparam logic [7:0]  TMO_LIM   = TIMEOUT[7:0];
  localparam logic [31:0] TMO_DATA  = 32'hDEAD_BEEF;

  // The state encoding doubles as the one-hot grant vector.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } state_t;

  state_t      state;
  state_t      state_next;
  logic        last;
  logic [7:0]  cnt;
  logic        tmo;
  logic        active;
  logic        timeout;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
      last  <= 1'b1;
      cnt   <= 8'd0;
      tmo   <= 1'b0;
    end else begin
      state <= state_next;
      if (state_next != state) begin
        if (state_next == GNT0) begin
          last <= 1'b0;
        end else if (state_next == GNT1) begin
          last <= 1'b1;
        end
      end
      if ((state_next != state) || !active || s_wbs_ack_o || timeout) begin
        cnt <= 8'd0;
      end else begin
        cnt <= cnt + 8'd1;
      end
      // A timeout in the same cycle as a clear request leaves the flag set.
      if (timeout) begin
        tmo <= 1'b1;
      end else if (tmo_clr_i) begin
        tmo <= 1'b0;
      end
    end
  end

  // Grants are never pre-empted; handover to a waiting master skips IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (m0_wbs_cyc_i && m1_wbs_cyc_i) begin
          state_next = last ? GNT0 : GNT1;
        end else if (m0_wbs_cyc_i) begin
          state_next = GNT0;
        end else if (m1_wbs_cyc_i) begin
          state_next = GNT1;
        end
      end
      GNT0: begin
        if (!m0_wbs_cyc_i) begin
          state_next = m1_wbs_cyc_i ? GNT1 : IDLE;
        end
      end
      GNT1: begin
        if (!m1_wbs_cyc_i) begin
          state_next = m0_wbs_cyc_i ? GNT0 : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    active = 1'b0;
    case (state)
      GNT0:    active = m0_wbs_cyc_i && m0_wbs_stb_i;
      GNT1:    active = m1_wbs_cyc_i && m1_wbs_stb_i;
      default: active = 1'b0;
    endcase
    timeout = active && !s_wbs_ack_o && (cnt == TMO_LIM);
  end

  // A real slave ack always beats the forced one.
  always_comb begin
    s_wbs_cyc_i  = 1'b0;
    s_wbs_stb_i  = 1'b0;
    s_wbs_we_i   = 1'b0;
    s_wbs_sel_i  = 4'h0;
    s_wbs_adr_i  = 32'h0;
    s_wbs_dat_i  = 32'h0;
    m0_wbs_ack_o = 1'b0;
    m0_wbs_dat_o = 32'h0;
    m1_wbs_ack_o = 1'b0;
    m1_wbs_dat_o = 32'h0;
    case (state)
      GNT0: begin
        s_wbs_cyc_i  = m0_wbs_cyc_i;
        s_wbs_stb_i  = m0_wbs_stb_i;
        s_wbs_we_i   = m0_wbs_we_i;
        s_wbs_sel_i  = m0_wbs_sel_i;
        s_wbs_adr_i  = m0_wbs_adr_i;
        s_wbs_dat_i  = m0_wbs_dat_i;
        m0_wbs_ack_o = s_wbs_ack_o;
        m0_wbs_dat_o = s_wbs_dat_o;
        if (timeout) begin
          s_wbs_cyc_i  = 1'b0;
          s_wbs_stb_i  = 1'b0;
          m0_wbs_ack_o = 1'b1;
          m0_wbs_dat_o = TMO_DATA;
        end
      end
      GNT1: begin
        s_wbs_cyc_i  = m1_wbs_cyc_i;
        s_wbs_stb_i  = m1_wbs_stb_i;
        s_wbs_we_i   = m1_wbs_we_i;
        s_wbs_sel_i  = m1_wbs_sel_i;
        s_wbs_adr_i  = m1_wbs_adr_i;
        s_wbs_dat_i  = m1_wbs_dat_i;
        m1_wbs_ack_o = s_wbs_ack_o;
        m1_wbs_dat_o = s_wbs_dat_o;
        if (timeout) begin
          s_wbs_cyc_i  = 1'b0;
          s_wbs_stb_i  = 1'b0;
          m1_wbs_ack_o = 1'b1;
          m1_wbs_dat_o = TMO_DATA;
        end
      end
      default: ;
    endcase
  end

  assign gnt_o = state;
  assign tmo_o = tmo;

endmodule

// File: doc/wb_rr_arbiter.md
WB_RR_ARBITER -- requirements
Module: wb_rr_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16: the number of stalled strobe cycles before a forced ack. The legal range is 1..255.
REQ-002 SHALL have port wb_clk_i, input, 1 bit: the single clock. All state updates on the rising edge.
REQ-003 SHALL have port wb_rst_i, input, 1 bit: reset, synchronous, active-high.
REQ-004 SHALL have ports m0_wbs_cyc_i / m0_wbs_stb_i / m0_wbs_we_i, input, 1 bit each: master 0 (management core) bus cycle, strobe and write enable.
REQ-005 SHALL have ports m0_wbs_sel_i, input, 4 bits; m0_wbs_adr_i, input, 32 bits; m0_wbs_dat_i, input, 32 bits: master 0 byte select, address and write data.
REQ-006 SHALL have ports m0_wbs_ack_o, output, 1 bit; m0_wbs_dat_o, output, 32 bits: master 0 acknowledge and read data.
REQ-007 SHALL have the m1_wbs_* port set, identical to REQ-004..REQ-006, for master 1 (user DMA requester).
REQ-008 SHALL have ports s_wbs_cyc_i / s_wbs_stb_i / s_wbs_we_i, output, 1 bit each; s_wbs_sel_i, output, 4 bits; s_wbs_adr_i / s_wbs_dat_i, output, 32 bits each: the shared slave port, feeding the existing decoder.
REQ-009 SHALL have ports s_wbs_ack_o, input, 1 bit; s_wbs_dat_o, input, 32 bits: slave acknowledge and read data.
REQ-010 SHALL have port gnt_o, output, 2 bits: the current grant, one-hot. 2'b00 means idle.
REQ-011 SHALL have port tmo_o, output, 1 bit: sticky timeout flag.
REQ-012 SHALL have port tmo_clr_i, input, 1 bit: clears tmo_o.

Function
REQ-013 SHALL implement the FSM states IDLE, GNT0 and GNT1. gnt_o is 00, 01 and 10 respectively.
REQ-014 SHALL use a last-grant pointer `last` for arbitration. A tie goes to the master not equal to `last`.
REQ-015 IDLE transitions SHALL be:
  - m0 cyc only -> GNT0.
  - m1 cyc only -> GNT1.
  - both -> per REQ-014.
  - neither -> stay IDLE.
  The grant registers on the next edge. There is one cycle of latency from cyc to slave cyc.
REQ-016 GNTx SHALL hold while mx_wbs_cyc_i=1. A grant is never pre-empted, regardless of the other master's requests.
REQ-017 GNTx with mx cyc=0 SHALL transition as follows:
  - other master cyc=1 -> GNTother directly, with no dead cycle.
  - otherwise -> IDLE.
REQ-018 `last` SHALL be updated to x on every entry to GNTx.
REQ-019 In GNTx, the s_wbs_* outputs SHALL equal master x's inputs combinationally.
REQ-020 In GNTx, mx_wbs_ack_o SHALL equal s_wbs_ack_o and mx_wbs_dat_o SHALL equal s_wbs_dat_o. Exception: the forced-ack cycle (REQ-023).
REQ-021 The non-granted master, and both masters in IDLE, SHALL see ack=0 and dat=0. In IDLE, s_wbs_cyc_i=0 and s_wbs_stb_i=0; the other slave outputs are don't-care and are driven 0.
REQ-022 The stall counter `cnt` (8-bit) SHALL:
  - increment each cycle in GNTx while mx cyc&stb=1 and s_wbs_ack_o=0;
  - clear on s_wbs_ack_o=1, on stb=0, and on any state change.
REQ-023 When cnt==TIMEOUT and s_wbs_ack_o=0, the arbiter SHALL, that cycle:
  - assert mx_wbs_ack_o=1 with mx_wbs_dat_o=32'hDEAD_BEEF;
  - force s_wbs_cyc_i=0 and s_wbs_stb_i=0;
  - clear cnt and set tmo_o on the next edge.
REQ-024 When cnt==TIMEOUT and s_wbs_ack_o=1, the slave ack SHALL take precedence, with normal ack and data. No timeout occurs and tmo_o is unchanged.
REQ-025 tmo_o SHALL clear on tmo_clr_i=1. When a set and a clear occur in the same cycle, set wins.
REQ-026 A master dropping cyc mid-transfer SHALL be legal. The slave cycle ends combinationally with it, and the REQ-017 transition applies.

Reset
REQ-027 On wb_rst_i=1 at an edge, the arbiter SHALL reset to: state IDLE, last=1 (so m0 wins the first tie), cnt=0, tmo_o=0.
REQ-028 Reset SHALL take effect mid-grant. The cycle after the reset edge has gnt_o=00, s_wbs_cyc_i=0, and both master acks=0.

Verification
REQ-029 Single master: m0 read at 0x3800_0010, slave acks 2 cycles after s_wbs_stb_i with dat 0x1234_5678 -> gnt_o=01 one cycle after m0 cyc; m0 ack with 0x1234_5678; m1 ack=0; state returns to IDLE after cyc drops.
REQ-030 Tie and round-robin: both cyc rise in the same cycle after reset -> GNT0 first. When m0 drops cyc while m1 is still requesting -> next cycle GNT1 with no IDLE cycle. When both then re-request from IDLE -> GNT0 (last=1).
REQ-031 No pre-emption: m1 requests while m0 holds cyc for a 3-beat burst to 0x3000_0000 -> gnt_o stays 01 through all three acks, then moves to 10.
REQ-032 Timeout: TIMEOUT=4, m1 write, slave never acks -> forced m1 ack with 0xDEAD_BEEF on the 5th stb cycle; s_wbs_stb_i=0 that cycle; tmo_o=1 afterwards; tmo_clr_i pulse -> tmo_o=0.
REQ-033 Reset mid-grant: wb_rst_i asserted during GNT1 with s stalled -> next cycle gnt_o=00, s_wbs_cyc_i=0, cnt=0, tmo_o=0. A subsequent tie is granted to m0.
